// File: rtl/branch_predictor_if.sv
// Port bundle between the fetch/resolve stages and branch_predictor.
// The predictor connects through the slave modport; the pipeline drives through master.
interface branch_predictor_if #(
    parameter int IDX_W = 6
);
    logic             i_req_valid;
    logic [31:0]      i_req_pc;
    logic             o_pred_valid;
    logic             o_pred_taken;
    logic [31:0]      o_pred_target;
    logic [IDX_W-1:0] o_pred_ghr;
    logic             i_upd_valid;
    logic [31:0]      i_upd_pc;
    logic [6:0]       i_upd_op;
    logic             i_upd_taken;
    logic [31:0]      i_upd_target;
    logic             i_upd_pred_taken;
    logic [31:0]      i_upd_pred_target;
    logic [IDX_W-1:0] i_upd_ghr;
    logic             o_mispredict;

    modport master (
        output i_req_valid, i_req_pc,
        output i_upd_valid, i_upd_pc, i_upd_op, i_upd_taken, i_upd_target,
        output i_upd_pred_taken, i_upd_pred_target, i_upd_ghr,
        input  o_pred_valid, o_pred_taken, o_pred_target, o_pred_ghr, o_mispredict
    );

    modport slave (
        input  i_req_valid, i_req_pc,
        input  i_upd_valid, i_upd_pc, i_upd_op, i_upd_taken, i_upd_target,
        input  i_upd_pred_taken, i_upd_pred_target, i_upd_ghr,
        output o_pred_valid, o_pred_taken, o_pred_target, o_pred_ghr, o_mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter table plus direct-mapped BTB, trained by resolved branches.
// Define BP_GHR_EN for gshare indexing with a global history register.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int BTB_W = 4,
    parameter int TAG_W = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned CTR_N = 2 ** IDX_W;
    localparam int unsigned BTB_N = 2 ** BTB_W;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    ctr_t             ctr        [CTR_N];
    logic             btb_valid  [BTB_N];
    logic             btb_uncond [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]      btb_target [BTB_N];

    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] upd_hist;

`ifdef BP_GHR_EN
    logic [IDX_W-1:0] ghr;
    assign hist     = ghr;
    assign upd_hist = bp.i_upd_ghr;
`else
    assign hist          = '0;
    assign upd_hist      = '0;
    assign bp.o_pred_ghr = '0;
`endif

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [BTB_W-1:0] lk_bidx, up_bidx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, lk_taken;
    logic [31:0]      lk_target;
    logic             up_act, up_uncond, up_mis;
    ctr_t             up_ctr;

    always_comb begin
        lk_idx    = bp.i_req_pc[IDX_W+1:2] ^ hist;
        lk_bidx   = bp.i_req_pc[BTB_W+1:2];
        lk_tag    = bp.i_req_pc[BTB_W+2 +: TAG_W];
        lk_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
        lk_taken  = lk_hit && (btb_uncond[lk_bidx] || ctr[lk_idx][1]);
        lk_target = lk_taken ? btb_target[lk_bidx] : bp.i_req_pc + 32'd4;

        up_idx    = bp.i_upd_pc[IDX_W+1:2] ^ upd_hist;
        up_bidx   = bp.i_upd_pc[BTB_W+1:2];
        up_tag    = bp.i_upd_pc[BTB_W+2 +: TAG_W];
        up_act    = bp.i_upd_valid && (bp.i_upd_op[6:4] == 3'b110);
        up_uncond = (bp.i_upd_op[2:0] == 3'b111);
        up_mis    = (bp.i_upd_pred_taken != bp.i_upd_taken) ||
                    (bp.i_upd_taken && (bp.i_upd_pred_target != bp.i_upd_target));
    end

    always_comb begin
        up_ctr = ctr[up_idx];
        if (up_uncond) begin
            up_ctr = STRONG_T;
        end else if (bp.i_upd_taken) begin
            case (ctr[up_idx])
                STRONG_NT: up_ctr = WEAK_NT;
                WEAK_NT:   up_ctr = WEAK_T;
                default:   up_ctr = STRONG_T;
            endcase
        end else begin
            case (ctr[up_idx])
                STRONG_T: up_ctr = WEAK_T;
                WEAK_T:   up_ctr = WEAK_NT;
                default:  up_ctr = STRONG_NT;
            endcase
        end
    end

    // Lookup reads the tables before this edge's update lands, so a same-cycle
    // lookup/update pair sees the old state without any bypass path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < CTR_N; i++) ctr[i] <= WEAK_NT;
            for (int unsigned i = 0; i < BTB_N; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_uncond[i] <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
            bp.o_pred_valid  <= 1'b0;
            bp.o_pred_taken  <= 1'b0;
            bp.o_pred_target <= '0;
            bp.o_mispredict  <= 1'b0;
`ifdef BP_GHR_EN
            bp.o_pred_ghr    <= '0;
            ghr              <= '0;
`endif
        end else begin
            bp.o_pred_valid <= bp.i_req_valid;
            if (bp.i_req_valid) begin
                bp.o_pred_taken  <= lk_taken;
                bp.o_pred_target <= lk_target;
`ifdef BP_GHR_EN
                bp.o_pred_ghr    <= ghr;
`endif
            end
            bp.o_mispredict <= up_act && up_mis;
            if (up_act) begin
                ctr[up_idx] <= up_ctr;
                if (up_uncond || bp.i_upd_taken) begin
                    btb_valid[up_bidx]  <= 1'b1;
                    btb_uncond[up_bidx] <= up_uncond;
                    btb_tag[up_bidx]    <= up_tag;
                    btb_target[up_bidx] <= bp.i_upd_target;
                end
            end
`ifdef BP_GHR_EN
            // A mispredict rebuilds history from the snapshot carried with the branch.
            if (up_act && !up_uncond) begin
                ghr <= up_mis ? {bp.i_upd_ghr[IDX_W-2:0], bp.i_upd_taken}
                              : {ghr[IDX_W-2:0], bp.i_upd_taken};
            end
`endif
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor; builds with or without BP_GHR_EN.
module tb_branch_predictor;
    localparam int IDX_W = 6;
    localparam int BTB_W = 4;
    localparam int TAG_W = 8;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ALU = 7'b0110011;
`ifdef BP_GHR_EN
    localparam bit GHR_ON = 1'b1;
`else
    localparam bit GHR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.IDX_W(IDX_W)) bif ();

    branch_predictor #(.IDX_W(IDX_W), .BTB_W(BTB_W), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bp      (bif.slave)
    );

    typedef struct {
        logic             req;
        logic             taken;
        logic [31:0]      target;
        logic [IDX_W-1:0] ghr;
        logic             mis;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference state of the predictor
    logic [1:0]       m_ctr [64];
    logic             m_bv  [16];
    logic             m_bu  [16];
    int unsigned      m_tag [16];
    logic [31:0]      m_tgt [16];
    logic [IDX_W-1:0] m_ghr;

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 2'd1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 1'b0; m_bu[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'h0;
        end
        m_ghr = '0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int unsigned idx, b, tag;
        logic hit;
        idx = ((pc >> 2) ^ (GHR_ON ? 32'(m_ghr) : 32'd0)) % 64;
        b   = (pc >> 2) % 16;
        tag = (pc >> 6) % 256;
        hit = m_bv[b] && (m_tag[b] == tag);
        t   = hit && (m_bu[b] || (m_ctr[idx] >= 2'd2));
        tgt = t ? m_tgt[b] : pc + 32'd4;
    endtask

    task automatic m_update(output logic mis);
        int unsigned idx, b;
        logic uncond, tk;
        logic [IDX_W-1:0] ug;
        mis = 1'b0;
        if (bif.i_upd_valid && bif.i_upd_op[6:4] == 3'b110) begin
            tk     = bif.i_upd_taken;
            ug     = bif.i_upd_ghr;
            uncond = (bif.i_upd_op[2:0] == 3'b111);
            idx    = ((bif.i_upd_pc >> 2) ^ (GHR_ON ? 32'(ug) : 32'd0)) % 64;
            b      = (bif.i_upd_pc >> 2) % 16;
            mis    = (bif.i_upd_pred_taken != tk) ||
                     (tk && bif.i_upd_pred_target != bif.i_upd_target);
            if (uncond) m_ctr[idx] = 2'd3;
            else if (tk && m_ctr[idx] != 2'd3) m_ctr[idx] = m_ctr[idx] + 2'd1;
            else if (!tk && m_ctr[idx] != 2'd0) m_ctr[idx] = m_ctr[idx] - 2'd1;
            if (uncond || tk) begin
                m_bv[b] = 1'b1; m_bu[b] = uncond;
                m_tag[b] = (bif.i_upd_pc >> 6) % 256; m_tgt[b] = bif.i_upd_target;
            end
            if (GHR_ON && !uncond) m_ghr = mis ? {ug[IDX_W-2:0], tk} : {m_ghr[IDX_W-2:0], tk};
        end
    endtask

    task automatic clear();
        bif.i_req_valid = 1'b0; bif.i_req_pc = 32'h0;
        bif.i_upd_valid = 1'b0; bif.i_upd_pc = 32'h0; bif.i_upd_op = 7'h0;
        bif.i_upd_taken = 1'b0; bif.i_upd_target = 32'h0;
        bif.i_upd_pred_taken = 1'b0; bif.i_upd_pred_target = 32'h0; bif.i_upd_ghr = '0;
    endtask

    task automatic set_req(input logic [31:0] pc);
        bif.i_req_valid = 1'b1; bif.i_req_pc = pc;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [6:0] op, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                           input logic [IDX_W-1:0] g);
        bif.i_upd_valid = 1'b1; bif.i_upd_pc = pc; bif.i_upd_op = op;
        bif.i_upd_taken = t; bif.i_upd_target = tgt;
        bif.i_upd_pred_taken = pt; bif.i_upd_pred_target = ptgt; bif.i_upd_ghr = g;
    endtask

    // Expected outputs are computed from the pre-edge model state, then queued after the edge.
    task automatic tick();
        exp_t e;
        e.req = bif.i_req_valid; e.taken = 1'b0; e.target = 32'h0; e.ghr = '0;
        if (e.req) begin
            m_lookup(bif.i_req_pc, e.taken, e.target);
            e.ghr = GHR_ON ? m_ghr : '0;
        end
        m_update(e.mis);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) sb.delete();
            else if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bif.o_pred_valid !== e.req) begin
                    miscompares++;
                    $display("FAIL sb_valid: got %b want %b", bif.o_pred_valid, e.req);
                end
                if (e.req) begin
                    vectors++;
                    if (bif.o_pred_taken !== e.taken) begin
                        miscompares++;
                        $display("FAIL sb_taken: got %b want %b", bif.o_pred_taken, e.taken);
                    end
                    vectors++;
                    if (bif.o_pred_target !== e.target) begin
                        miscompares++;
                        $display("FAIL sb_target: got %h want %h", bif.o_pred_target, e.target);
                    end
                    vectors++;
                    if (bif.o_pred_ghr !== e.ghr) begin
                        miscompares++;
                        $display("FAIL sb_ghr: got %h want %h", bif.o_pred_ghr, e.ghr);
                    end
                end
                vectors++;
                if (bif.o_mispredict !== e.mis) begin
                    miscompares++;
                    $display("FAIL sb_mispredict: got %b want %b", bif.o_mispredict, e.mis);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bif.o_pred_valid, bif.o_pred_taken, bif.o_mispredict} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000",
                     {bif.o_pred_valid, bif.o_pred_taken, bif.o_mispredict});
        end
        vectors++;
        if (bif.o_pred_target !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_target: got %h want 0", bif.o_pred_target);
        end
        vectors++;
        if (bif.o_pred_ghr !== '0) begin
            miscompares++;
            $display("FAIL reset_ghr: got %h want 0", bif.o_pred_ghr);
        end
        rst_n = 1'b1;
        set_req(32'h100);
        tick();
        clear();
        vectors++;
        if ({bif.o_pred_valid, bif.o_pred_taken} !== 2'b10) begin
            miscompares++;
            $display("FAIL first_lookup_flags: got %b want 10", {bif.o_pred_valid, bif.o_pred_taken});
        end
        vectors++;
        if (bif.o_pred_target !== 32'h104) begin
            miscompares++;
            $display("FAIL first_lookup_target: got %h want 104", bif.o_pred_target);
        end
        tick();
        vectors++;
        if (bif.o_pred_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_valid: got %b want 0", bif.o_pred_valid);
        end
    endtask

    task automatic test_counter();
        repeat (2) begin
            set_upd(32'h100, OP_BEQ, 1'b1, 32'h80, 1'b0, 32'h104, '0);
            tick();
        end
        clear(); set_req(32'h100); tick(); clear();
`ifndef BP_GHR_EN
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b1, 32'h80}) begin
            miscompares++;
            $display("FAIL ctr_strong_taken: got %b/%h want 1/80", bif.o_pred_taken, bif.o_pred_target);
        end
`endif
        set_upd(32'h100, OP_BEQ, 1'b0, 32'h104, 1'b1, 32'h80, '0); tick(); clear();
        set_req(32'h100); tick(); clear();
`ifndef BP_GHR_EN
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b1, 32'h80}) begin
            miscompares++;
            $display("FAIL ctr_weak_taken: got %b/%h want 1/80", bif.o_pred_taken, bif.o_pred_target);
        end
`endif
        set_upd(32'h100, OP_BEQ, 1'b0, 32'h104, 1'b1, 32'h80, '0); tick(); clear();
        set_req(32'h100); tick(); clear();
`ifndef BP_GHR_EN
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b0, 32'h104}) begin
            miscompares++;
            $display("FAIL ctr_weak_nt: got %b/%h want 0/104", bif.o_pred_taken, bif.o_pred_target);
        end
`endif
    endtask

    task automatic test_jal();
        set_upd(32'h200, OP_JAL, 1'b1, 32'h400, 1'b0, 32'h204, '0); tick(); clear();
        set_req(32'h200); tick(); clear();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b1, 32'h400}) begin
            miscompares++;
            $display("FAIL jal_pred: got %b/%h want 1/400", bif.o_pred_taken, bif.o_pred_target);
        end
        repeat (3) begin
            set_upd(32'h200, OP_BEQ, 1'b0, 32'h204, 1'b1, 32'h400, '0); tick();
        end
        clear(); set_req(32'h200); tick(); clear();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b1, 32'h400}) begin
            miscompares++;
            $display("FAIL jal_sticky: got %b/%h want 1/400", bif.o_pred_taken, bif.o_pred_target);
        end
    endtask

    task automatic test_mispredict();
        set_upd(32'h300, OP_BEQ, 1'b1, 32'h380, 1'b0, 32'h304, '0); tick(); clear();
        vectors++;
        if (bif.o_mispredict !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_dir: got %b want 1", bif.o_mispredict);
        end
        tick();
        vectors++;
        if (bif.o_mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_one_cycle: got %b want 0", bif.o_mispredict);
        end
        set_upd(32'h300, OP_BEQ, 1'b1, 32'h380, 1'b1, 32'h388, '0); tick(); clear();
        vectors++;
        if (bif.o_mispredict !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_target: got %b want 1", bif.o_mispredict);
        end
        set_upd(32'h300, OP_BEQ, 1'b1, 32'h380, 1'b1, 32'h380, '0); tick(); clear();
        vectors++;
        if (bif.o_mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_correct: got %b want 0", bif.o_mispredict);
        end
        set_upd(32'h340, OP_ALU, 1'b1, 32'h900, 1'b0, 32'h344, '0); tick(); clear();
        vectors++;
        if (bif.o_mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_non_branch: got %b want 0", bif.o_mispredict);
        end
        set_req(32'h340); tick(); clear();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b0, 32'h344}) begin
            miscompares++;
            $display("FAIL non_branch_no_write: got %b/%h want 0/344", bif.o_pred_taken, bif.o_pred_target);
        end
    endtask

    task automatic test_alias();
        repeat (2) begin
            set_upd(32'h100, OP_BEQ, 1'b1, 32'h80, 1'b0, 32'h104, '0); tick();
        end
        clear();
        set_req(32'h100 + (32'd4 << BTB_W)); tick(); clear();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b0, 32'h144}) begin
            miscompares++;
            $display("FAIL alias_miss: got %b/%h want 0/144", bif.o_pred_taken, bif.o_pred_target);
        end
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        set_req(32'h300);
        set_upd(32'h300, OP_JAL, 1'b1, 32'h500, 1'b0, 32'h304, '0);
        tick(); clear();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b0, 32'h304}) begin
            miscompares++;
            $display("FAIL same_cycle_old: got %b/%h want 0/304", bif.o_pred_taken, bif.o_pred_target);
        end
        set_req(32'h300); tick();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b1, 32'h500}) begin
            miscompares++;
            $display("FAIL same_cycle_new: got %b/%h want 1/500", bif.o_pred_taken, bif.o_pred_target);
        end
        set_upd(32'h300, OP_BEQ, 1'b1, 32'h500, 1'b0, 32'h304, '0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bif.o_pred_valid, bif.o_pred_taken, bif.o_mispredict, bif.o_pred_target, bif.o_pred_ghr} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b%b%b/%h/%h want all 0", bif.o_pred_valid,
                     bif.o_pred_taken, bif.o_mispredict, bif.o_pred_target, bif.o_pred_ghr);
        end
        clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        set_req(32'h300); tick(); clear();
        vectors++;
        if ({bif.o_pred_taken, bif.o_pred_target} !== {1'b0, 32'h304}) begin
            miscompares++;
            $display("FAIL reset_clears_btb: got %b/%h want 0/304", bif.o_pred_taken, bif.o_pred_target);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [6];
        logic [6:0]  ops [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h140;
        pcs[3] = 32'h200; pcs[4] = 32'h300; pcs[5] = 32'hFFFF_FFFC;
        ops[0] = OP_BEQ; ops[1] = OP_JAL; ops[2] = OP_ALU;
        for (int i = 0; i < 400; i++) begin
            clear();
            if ($urandom_range(0, 3) != 0) set_req(pcs[$urandom_range(0, 5)]);
            if ($urandom_range(0, 1) != 0)
                set_upd(pcs[$urandom_range(0, 5)], ops[$urandom_range(0, 2)],
                        1'($urandom_range(0, 1)), 32'h40 << $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 32'h40 << $urandom_range(0, 3),
                        IDX_W'($urandom_range(0, 63)));
            tick();
        end
        clear();
        tick();
    endtask

`ifdef BP_GHR_EN
    task automatic test_ghr_pattern();
        logic pt, tk;
        logic [31:0] ptgt;
        logic [IDX_W-1:0] g;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            set_req(32'h180); tick(); clear();
            pt = bif.o_pred_taken; ptgt = bif.o_pred_target; g = bif.o_pred_ghr;
            tk = (i % 2 == 0);
            set_upd(32'h180, OP_BEQ, tk, tk ? 32'h40 : 32'h184, pt, ptgt, g);
            tick(); clear();
            if (i >= 16) begin
                vectors++;
                if (bif.o_mispredict !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ghr_pattern_iter%0d: got mispredict %b want 0", i, bif.o_mispredict);
                end
            end
        end
    endtask
`endif

    initial begin
        clear();
        m_reset();
        test_reset();
        test_counter();
        test_jal();
        test_mispredict();
        test_alias();
        test_same_cycle_and_reset();
        test_back_to_back();
`ifdef BP_GHR_EN
        test_ghr_pattern();
`endif
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
